// File: rtl/xif_bus_arbiter_if.sv
// xif_bus_arbiter_if
//  Bundles the shared peripheral CSR bus around the round-robin arbiter.
//  Master-side fields are packed per requester: master i owns the 32-bit slice
//  [32*i+:32] of addr/wdata/rdata, [4*i+:4] of be and bit i of req/we/ack/resp.
//  Modports:
//   arb    - the arbiter itself (requests in from masters, request out to slave)
//   master - the requesters (tile xif ports, udm)
//   slave  - the single CSR decode block
interface xif_bus_arbiter_if #(
  parameter int N_MASTERS = 2
);
  logic [N_MASTERS-1:0]    m_req_i;
  logic [N_MASTERS-1:0]    m_we_i;
  logic [N_MASTERS*32-1:0] m_addr_bi;
  logic [N_MASTERS*4-1:0]  m_be_bi;
  logic [N_MASTERS*32-1:0] m_wdata_bi;
  logic [N_MASTERS-1:0]    m_ack_o;
  logic [N_MASTERS-1:0]    m_resp_o;
  logic [N_MASTERS*32-1:0] m_rdata_bo;

  logic                    s_req_o;
  logic                    s_we_o;
  logic [31:0]             s_addr_bo;
  logic [3:0]              s_be_bo;
  logic [31:0]             s_wdata_bo;
  logic                    s_ack_i;
  logic                    s_resp_i;
  logic [31:0]             s_rdata_bi;

  modport arb (
    input  m_req_i, m_we_i, m_addr_bi, m_be_bi, m_wdata_bi,
    output m_ack_o, m_resp_o, m_rdata_bo,
    output s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo,
    input  s_ack_i, s_resp_i, s_rdata_bi
  );

  modport master (
    output m_req_i, m_we_i, m_addr_bi, m_be_bi, m_wdata_bi,
    input  m_ack_o, m_resp_o, m_rdata_bo
  );

  modport slave (
    input  s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo,
    output s_ack_i, s_resp_i, s_rdata_bi
  );
endinterface

// File: rtl/xif_bus_arbiter.sv
// xif_bus_arbiter
//  Round-robin arbiter sharing one MemSplit32-style CSR bus between N_MASTERS
//  requesters. The granted master's request is passed through combinationally;
//  in-order read responses are steered back using a FIFO of requester ids.
//  Optional feature macro: XIF_ARB_WATCHDOG_EN (read-response watchdog, adds
//  RESP_TIMEOUT parameter and timeout_o port).
// Ports:
//  clk_i        clock
//  arst_n_i     asynchronous reset, active low
//  ifc          xif_bus_arbiter_if.arb: master request/ack/resp bundle + slave bus
//  rd_pending_o number of outstanding reads
//  resp_err_o   sticky: slave response arrived with no outstanding read
//  timeout_o    sticky: watchdog answered a stalled read (watchdog build only)
module xif_bus_arbiter #(
  parameter int N_MASTERS     = 2,
  parameter int RD_FIFO_DEPTH = 4
`ifdef XIF_ARB_WATCHDOG_EN
  , parameter int RESP_TIMEOUT = 1024
`endif
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  xif_bus_arbiter_if.arb                 ifc,
  output logic [$clog2(RD_FIFO_DEPTH):0] rd_pending_o,
  output logic                           resp_err_o
`ifdef XIF_ARB_WATCHDOG_EN
  , output logic                         timeout_o
`endif
);
  localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int AW  = $clog2(RD_FIFO_DEPTH);
  localparam int PW  = AW + 1;

  logic [IDW-1:0] r_rr;
  logic           r_lock;
  logic [IDW-1:0] r_lock_id;
  logic [IDW-1:0] r_fifo [RD_FIFO_DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [PW-1:0]  r_count;
  logic           r_err;

  logic           w_gnt_vld;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_acc;
  logic           w_push;
  logic           w_pop;
  logic [31:0]    w_pop_data;

  assign w_full  = (r_count == PW'(RD_FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // Scan from the highest offset down so the lowest offset from r_rr wins.
  // A locked grant is kept as-is; it was eligible when it was first issued.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    if (r_lock) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_lock_id;
    end else begin
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
        idx = (int'(r_rr) + k) % N_MASTERS;
        if (ifc.m_req_i[idx] && (ifc.m_we_i[idx] || !w_full)) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = IDW'(idx);
        end
      end
    end
  end

  assign w_acc  = w_gnt_vld & ifc.s_ack_i;
  assign w_push = w_acc & ~ifc.m_we_i[w_gnt_id];

`ifdef XIF_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(RESP_TIMEOUT) + 1;

  logic [WDW-1:0] r_wd_cnt;
  logic           r_timeout;
  logic           w_wd_fire;

  // Down-counter reloads whenever nothing is waiting or the head is retired,
  // so each head entry gets a full RESP_TIMEOUT cycles.
  assign w_wd_fire  = ~w_empty & ~ifc.s_resp_i & (r_wd_cnt == '0);
  assign w_pop      = (ifc.s_resp_i & ~w_empty) | w_wd_fire;
  assign w_pop_data = ifc.s_resp_i ? ifc.s_rdata_bi : 32'hDEADBEEF;
  assign timeout_o  = r_timeout;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wd_cnt  <= WDW'(RESP_TIMEOUT - 1);
      r_timeout <= 1'b0;
    end else begin
      if (w_empty || w_pop) r_wd_cnt <= WDW'(RESP_TIMEOUT - 1);
      else                  r_wd_cnt <= r_wd_cnt - 1'b1;
      if (w_wd_fire)        r_timeout <= 1'b1;
    end
  end
`else
  assign w_pop      = ifc.s_resp_i & ~w_empty;
  assign w_pop_data = ifc.s_rdata_bi;
`endif

  always_comb begin
    ifc.s_req_o    = 1'b0;
    ifc.s_we_o     = 1'b0;
    ifc.s_addr_bo  = '0;
    ifc.s_be_bo    = '0;
    ifc.s_wdata_bo = '0;
    ifc.m_ack_o    = '0;
    if (w_gnt_vld) begin
      ifc.s_req_o    = 1'b1;
      ifc.s_we_o     = ifc.m_we_i[w_gnt_id];
      ifc.s_addr_bo  = ifc.m_addr_bi[32*int'(w_gnt_id) +: 32];
      ifc.s_be_bo    = ifc.m_be_bi[4*int'(w_gnt_id) +: 4];
      ifc.s_wdata_bo = ifc.m_wdata_bi[32*int'(w_gnt_id) +: 32];
      ifc.m_ack_o[w_gnt_id] = ifc.s_ack_i;
    end
  end

  always_comb begin
    ifc.m_resp_o   = '0;
    ifc.m_rdata_bo = '0;
    if (w_pop) begin
      ifc.m_resp_o[w_head]                   = 1'b1;
      ifc.m_rdata_bo[32*int'(w_head) +: 32] = w_pop_data;
    end
  end

  assign rd_pending_o = r_count;
  assign resp_err_o   = r_err;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rr      <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < RD_FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_lock <= w_gnt_vld & ~ifc.s_ack_i;
      if (w_gnt_vld) r_lock_id <= w_gnt_id;
      if (w_acc)     r_rr <= IDW'((int'(w_gnt_id) + 1) % N_MASTERS);
      if (w_push) begin
        r_fifo[r_wptr] <= w_gnt_id;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop)               r_rptr  <= r_rptr + 1'b1;
      if (w_push && !w_pop)    r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (ifc.s_resp_i && w_empty) r_err <= 1'b1;
    end
  end
endmodule
